// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder with RISC-V byte/half/word sizing and load extension.
// Optional `DMEM_MISALIGN_TRAP_EN: misaligned accesses flag rsp_err, return 0 and write nothing.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit USE_REQ = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q, valid_q, err_q;
    logic [31:0]   rdata_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic [31:0] mem [DEPTH];

    logic          accept, to_resp, we_en;
    logic          a_we;
    logic [2:0]    a_f3;
    logic [AW+1:0] a_addr;
    logic [31:0]   a_wdata;
    logic          is_byte, is_half, trap;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [7:0]    b_val;
    logic [15:0]   h_val;
    logic [31:0]   word, load_val, wshift, merged, rdata_d;
    logic [3:0]    bmask;
    logic          unused_hi;

    // Address bits above the array wrap around and are deliberately dropped.
    assign unused_hi = ^req_addr[31:AW+2];

    assign accept  = req_valid & ready_q;
    assign to_resp = (USE_REQ && accept) || (state_q == WAIT && cnt_q == CW'(1));

    // With single-cycle latency the access resolves straight from the request lines.
    always_comb begin
        a_we    = USE_REQ ? req_we            : we_q;
        a_f3    = USE_REQ ? req_funct3        : f3_q;
        a_addr  = USE_REQ ? req_addr[AW+1:0]  : addr_q;
        a_wdata = USE_REQ ? req_wdata         : wdata_q;
        is_byte = (a_f3[1:0] == 2'b00);
        is_half = (a_f3[1:0] == 2'b01);
`ifdef DMEM_MISALIGN_TRAP_EN
        trap = (is_half && a_addr[0]) || (!is_byte && !is_half && (a_addr[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
        lane  = is_byte ? a_addr[1:0] : (is_half ? {a_addr[1], 1'b0} : 2'b00);
        idx   = a_addr[AW+1:2];
        word  = mem[idx];
        b_val = word[{lane, 3'b000} +: 8];
        h_val = word[{lane[1], 4'b0000} +: 16];
        if (is_byte)
            load_val = a_f3[2] ? {24'h0, b_val} : {{24{b_val[7]}}, b_val};
        else if (is_half)
            load_val = a_f3[2] ? {16'h0, h_val} : {{16{h_val[15]}}, h_val};
        else
            load_val = word;
        bmask  = is_byte ? (4'b0001 << lane) : (is_half ? (4'b0011 << lane) : 4'b1111);
        wshift = a_wdata << {lane, 3'b000};
        merged = word;
        for (int b = 0; b < 4; b++)
            if (bmask[b]) merged[8*b +: 8] = wshift[8*b +: 8];
        rdata_d = (a_we || trap) ? 32'h0 : load_val;
    end

    // Gating with reset keeps a store from landing while the FSM is held in reset.
    assign we_en = to_resp & a_we & ~trap & reset;

    always_ff @(posedge clk) begin
        if (we_en) mem[idx] <= merged;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= to_resp;
            if (to_resp) begin
                rdata_q <= rdata_d;
                err_q   <= trap;
            end
            case (state_q)
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        if (USE_REQ) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CW'(LATENCY - 1);
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (LATENCY 2 and 1) against a byte-array memory model.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int NB    = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv[2], rrdy[2], rwe[2], rsv[2], rerr[2];
    logic [2:0]  rf3[2];
    logic [31:0] raddr[2], rwd[2], rrd[2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rrdy[0]), .req_we(rwe[0]),
        .req_funct3(rf3[0]), .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .rsp_valid(rsv[0]), .rsp_rdata(rrd[0]), .rsp_err(rerr[0]));

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rrdy[1]), .req_we(rwe[1]),
        .req_funct3(rf3[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .rsp_valid(rsv[1]), .rsp_rdata(rrd[1]), .rsp_err(rerr[1]));

    typedef struct {
        int          d;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          acc;
        logic        has_k;
        logic [31:0] k_rd;
        logic        k_err;
    } req_t;

    req_t        q[$];
    int          last_resp[2];
    int          last_acc[2];
    logic [31:0] last_rd[2];
    logic        last_err[2];
    logic [7:0]  mm[2][NB];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: little-endian byte memory, size from funct3[1:0], extension from funct3[2].
    task automatic ref_access(input req_t it, output logic [31:0] rd, output logic err);
        int sz, a, base;
        logic [31:0] v;
        sz  = (it.f3[1:0] == 2'b00) ? 1 : ((it.f3[1:0] == 2'b01) ? 2 : 4);
        a   = int'(it.addr % NB);
        rd  = 32'h0;
        err = 1'b0;
        if (TRAP && (a % sz != 0)) begin
            err = 1'b1;
            return;
        end
        base = a - (a % sz);
        if (it.we) begin
            for (int i = 0; i < sz; i++) mm[it.d][base + i] = it.wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[it.d][base + i];
            if (!it.f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
            else if (!it.f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
            rd = v;
        end
    endtask

    always @(negedge clk) begin : mon
        req_t        it;
        logic [31:0] erd;
        logic        eerr;
        logic        ev;
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                ev = (q.size() > 0) && (q[0].d == d) && (cyc == q[0].acc + lat(d));
                chk($sformatf("rsp_valid[%0d]", d), 32'(rsv[d]), 32'(ev));
                chk($sformatf("req_ready[%0d]", d), 32'(rrdy[d]), 32'(cyc >= last_resp[d]));
                if (ev) begin
                    it = q.pop_front();
                    ref_access(it, erd, eerr);
                    chk($sformatf("rdata[%0d] a=%h", d, it.addr), rrd[d], erd);
                    chk($sformatf("err[%0d] a=%h", d, it.addr), 32'(rerr[d]), 32'(eerr));
                    if (it.has_k) begin
                        chk($sformatf("known_rdata[%0d] a=%h", d, it.addr), rrd[d], it.k_rd);
                        chk($sformatf("known_err[%0d] a=%h", d, it.addr), 32'(rerr[d]), 32'(it.k_err));
                    end
                    last_rd[d]  = erd;
                    last_err[d] = eerr;
                end else begin
                    chk($sformatf("hold_rdata[%0d]", d), rrd[d], last_rd[d]);
                    chk($sformatf("hold_err[%0d]", d), 32'(rerr[d]), 32'(last_err[d]));
                end
            end
        end
    end

    task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic hk = 1'b0, input logic [31:0] krd = 32'h0,
                          input logic kerr = 1'b0);
        req_t it;
        int   tries;
        bit   done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk); #1;
            rv[d] = 1'b1; rwe[d] = we; rf3[d] = f3; raddr[d] = addr; rwd[d] = wd;
            if (rrdy[d]) begin
                it.d = d; it.we = we; it.f3 = f3; it.addr = addr; it.wdata = wd;
                it.acc = cyc; it.has_k = hk; it.k_rd = krd; it.k_err = kerr;
                q.push_back(it);
                last_resp[d] = cyc + lat(d);
                last_acc[d]  = cyc;
                done = 1;
            end else begin
                tries++;
                if (tries > 20) begin
                    chk($sformatf("ready_timeout[%0d]", d), 32'd0, 32'd1);
                    rv[d] = 1'b0;
                    done  = 1;
                end
            end
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) begin
            @(negedge clk); #1;
            rv[d] = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input int d);
        chk($sformatf("rst_rsp_valid[%0d]", d), 32'(rsv[d]), 32'd0);
        chk($sformatf("rst_rdata[%0d]", d), rrd[d], 32'd0);
        chk($sformatf("rst_err[%0d]", d), 32'(rerr[d]), 32'd0);
        chk($sformatf("rst_ready[%0d]", d), 32'(rrdy[d]), 32'd1);
    endtask

    task automatic gap(input int d, input int prev, input int exp);
        chk($sformatf("accept_spacing[%0d]", d), 32'(last_acc[d] - prev), 32'(exp));
    endtask

    initial begin
        int p;
        logic we;
        logic [2:0] f3;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rwe[d] = 1'b0; rf3[d] = 3'b0; raddr[d] = 32'h0; rwd[d] = 32'h0;
            last_resp[d] = 0; last_acc[d] = 0; last_rd[d] = 32'h0; last_err[d] = 1'b0;
        end
        #3 reset = 1'b0;
        #5;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk); #2 reset = 1'b1;

        // Fill both memories so every later load has a defined reference.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH; w++) do_req(d, 1'b1, 3'b010, 32'(w * 4), $urandom);
            idle(d, 2);
        end

        // Directed sizing/lane checks on the LATENCY=2 instance, issued back to back.
        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        p = last_acc[0]; do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0); gap(0, p, 2);
        p = last_acc[0]; do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0); gap(0, p, 2);
        do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 32'h000000DE, 1'b0);
        do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'hFFFFDEAD, 1'b0);
        do_req(0, 1'b0, 3'b101, 32'h10, 32'h0, 1'b1, 32'h0000BEEF, 1'b0);
        do_req(0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 1'b1, 32'h0, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'hDEAD55EF, 1'b0);
        do_req(0, 1'b1, 3'b001, 32'h12, 32'hABCD1234, 1'b1, 32'h0, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h123455EF, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h110, 32'h0, 1'b1, 32'h123455EF, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h11, 32'h0, 1'b1, TRAP ? 32'h0 : 32'h123455EF, TRAP);
        do_req(0, 1'b0, 3'b001, 32'h13, 32'h0, 1'b1, TRAP ? 32'h0 : 32'h00001234, TRAP);
        idle(0, 3);

        // LATENCY=1: one accept per cycle, responses on consecutive cycles.
        do_req(1, 1'b1, 3'b010, 32'h4, 32'h0BADC0DE, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            p = last_acc[1];
            do_req(1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b1, 32'h0BADC0DE, 1'b0);
            gap(1, p, 1);
        end
        idle(1, 3);

        // Reset during WAIT drops the pending store.
        do_req(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b1, 32'h0, 1'b0);
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h11223344, 1'b0);
        do_req(0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D);
        @(negedge clk); #1;
        rv[0] = 1'b0;
        reset = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        q.delete();
        for (int d = 0; d < 2; d++) begin
            last_resp[d] = 0; last_rd[d] = 32'h0; last_err[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        do_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 32'h11223344, 1'b0);
        idle(0, 3);

        // Random traffic; addresses span past the array to exercise wrap-around.
        for (int d = 0; d < 2; d++) begin
            repeat (150) begin
                we = 1'($urandom_range(0, 1));
                f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
                do_req(d, we, f3, 32'($urandom_range(0, 1023)), $urandom);
                idle(d, $urandom_range(0, 2));
            end
            idle(d, 3);
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's load/store interface.
- Accepts one load or store request at a time over a valid/ready handshake.
- Models a fixed-latency memory with a wait-state counter, then returns a one-cycle response.
- Handles RISC-V byte/half/word sizing, lane selection and sign/zero extension, so the core datapath sees the final load value on rsp_rdata.

Parameters:
- DEPTH, 1024, number of 32-bit words of storage (power of two).
- LATENCY, 2, cycles from request acceptance to rsp_valid (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 size/sign code.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, already extended; 0 for stores.
- rsp_err  output  1  misaligned access flag, valid with rsp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
  - Memory contents are not cleared.
  - A reset asserted mid-transaction aborts it; a pending store that has not reached the RESP edge is not written.
- States: IDLE, WAIT, RESP.
- req_ready=1 in IDLE and in RESP, 0 in WAIT.
- Accept (req_valid & req_ready):
  - Latch we, funct3, addr, wdata.
  - If LATENCY==1, go to RESP. Otherwise go to WAIT with cnt=LATENCY-1.
- WAIT:
  - cnt==1 -> RESP.
  - Otherwise cnt decrements.
  - req_valid is ignored.
- Edge entering RESP:
  - Store performed, byte-enabled.
  - rsp_rdata/rsp_err registered.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - A new request accepted this cycle goes to WAIT or RESP as above. This gives back-to-back throughput of one transaction per LATENCY cycles.
  - Without a new request, go to IDLE.
- Latency: rsp_valid is asserted exactly LATENCY cycles after the accepting edge.
- Word index = addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
- funct3 decode:
  - 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
  - 011, 110, 111 are treated as word.
- Byte lane = addr[1:0]; half lane = addr[1].
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores write only the addressed bytes from the low bits of wdata; other bytes are unchanged.
- A store's rsp_rdata is 0.
- Misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
- rsp_rdata/rsp_err hold their value outside rsp_valid until the next response.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access returns rsp_err=1 and rsp_rdata=0.
  - A misaligned store writes nothing.
  - Timing is unchanged.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned accesses force alignment by clearing addr[0] for halves and addr[1:0] for words, then proceed normally.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF; rsp_valid exactly 2 cycles after each accept; req_ready low during WAIT.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF; SH 0x12 data 0x1234, then LW -> 0x123455EF.
- Request presented in the RESP cycle -> accepted that cycle; with LATENCY=1, four back-to-back LWs give rsp_valid high four consecutive cycles.
- LW 0x11:
  - With DMEM_MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0.
  - Without it -> rsp_err=0, data from 0x10.
- SW accepted, then reset asserted during WAIT and released, then LW same address -> old data returned; outputs zero and req_ready=1 immediately on reset.
